// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer input-capture path.
package timer_pkg;

  localparam int DEF_NUM_CH    = 8;
  localparam int DEF_CNT_WIDTH = 32;

  // Per-channel capture state: EMPTY = nothing pending, FULL = unread capture held.
  typedef enum logic {
    CAP_EMPTY = 1'b0,
    CAP_FULL  = 1'b1
  } cap_state_e;

  // Per-channel control strobes seen in one cycle.
  typedef struct packed {
    logic evt;      // edge_detected & cap_en
    logic ack;      // completed read of this channel
    logic ovf_clr;  // write-one-to-clear of the overrun flag
  } cap_ctrl_t;

  // A capture happens only on an enabled channel's edge.
  function automatic logic capture_event(input logic edge_pulse, input logic enable);
    return edge_pulse & enable;
  endfunction

endpackage

// File: rtl/timer_input_capture_channel.sv
// One capture channel: capture register, EMPTY/FULL state and sticky overrun flag.
module capture_channel
  import timer_pkg::*;
#(
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [CNT_WIDTH-1:0] count,
  input  cap_ctrl_t            ctrl,
  output logic [CNT_WIDTH-1:0] cap_reg,
  output logic                 cap_valid,
  output logic                 cap_ovf
);

  cap_state_e state;

  // An overrun is a capture landing on an unread value that is not being read this cycle.
  logic ovf_set;
  assign ovf_set = ctrl.evt & (state == CAP_FULL) & ~ctrl.ack;

  assign cap_valid = (state == CAP_FULL);

  // Channel state machine; a same-cycle capture wins over the ack and keeps the channel FULL.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state   <= CAP_EMPTY;
      cap_reg <= '0;
      cap_ovf <= 1'b0;
    end else begin
      case (state)
        CAP_EMPTY: begin
          if (ctrl.evt) begin
            state   <= CAP_FULL;
            cap_reg <= count;
          end
        end
        CAP_FULL: begin
          if (ctrl.evt) begin
            cap_reg <= count;
          end else if (ctrl.ack) begin
            state <= CAP_EMPTY;
          end
        end
        default: state <= CAP_EMPTY;
      endcase
      // Set beats clear when both land together.
      if (ovf_set)           cap_ovf <= 1'b1;
      else if (ctrl.ovf_clr) cap_ovf <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_input_capture.sv
// Input-capture stage: per-channel capture slots, read select/ack decode and level irq.
module timer_input_capture
  import timer_pkg::*;
#(
  parameter int NUM_CH    = DEF_NUM_CH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int CH_IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [CNT_WIDTH-1:0] count,
  input  logic [NUM_CH-1:0]    edge_detected,
  input  logic [NUM_CH-1:0]    cap_en,
  input  logic [NUM_CH-1:0]    irq_en,
  input  logic [CH_IDX_W-1:0]  rd_ch,
  input  logic                 rd_ack,
  input  logic [NUM_CH-1:0]    ovf_clr,
  output logic [CNT_WIDTH-1:0] rd_data,
  output logic [NUM_CH-1:0]    cap_valid,
  output logic [NUM_CH-1:0]    cap_ovf,
  output logic                 irq
);

  logic [NUM_CH-1:0][CNT_WIDTH-1:0] cap_regs;
  logic [NUM_CH-1:0]                ack_vec;

  // One extra bit so an out-of-range select can never alias a real channel.
  logic [CH_IDX_W:0] rd_ch_x;
  assign rd_ch_x = {1'b0, rd_ch};

  // Decode the ack to a one-hot channel strobe; out-of-range selects ack nothing.
  always_comb begin
    ack_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ack && (rd_ch_x == (CH_IDX_W+1)'(i))) ack_vec[i] = 1'b1;
    end
  end

  // Read mux; out-of-range selects read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_ch_x == (CH_IDX_W+1)'(i)) rd_data = cap_regs[i];
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cap_ctrl_t ctrl;
    assign ctrl.evt     = capture_event(edge_detected[g], cap_en[g]);
    assign ctrl.ack     = ack_vec[g];
    assign ctrl.ovf_clr = ovf_clr[g];

    capture_channel #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_ch (
      .clk       (clk),
      .n_rst     (n_rst),
      .count     (count),
      .ctrl      (ctrl),
      .cap_reg   (cap_regs[g]),
      .cap_valid (cap_valid[g]),
      .cap_ovf   (cap_ovf[g])
    );
  end

  // Level interrupt, registered one cycle behind the pending flags.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) irq <= 1'b0;
    else        irq <= |(cap_valid & irq_en);
  end

endmodule

// File: tb/tb_timer_input_capture.sv
// Bench for timer_input_capture: directed scenarios plus a randomized run against a slot model.
module tb_timer_input_capture;

  localparam int NCH = 8;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [31:0] count = '0;
  logic [7:0]  edge_detected = '0;
  logic [7:0]  cap_en = '0;
  logic [7:0]  irq_en = '0;
  logic [2:0]  rd_ch = '0;
  logic        rd_ack = 1'b0;
  logic [7:0]  ovf_clr = '0;
  logic [31:0] rd_data;
  logic [7:0]  cap_valid;
  logic [7:0]  cap_ovf;
  logic        irq;

  int total = 0;
  int bad = 0;

  // Reference: each channel is a mailbox slot holding the last captured count.
  logic [31:0] m_val [NCH];
  bit   [7:0]  m_full;
  bit   [7:0]  m_ovf;
  bit          m_irq;

  timer_input_capture dut (
    .clk           (clk),
    .n_rst         (n_rst),
    .count         (count),
    .edge_detected (edge_detected),
    .cap_en        (cap_en),
    .irq_en        (irq_en),
    .rd_ch         (rd_ch),
    .rd_ack        (rd_ack),
    .ovf_clr       (ovf_clr),
    .rd_data       (rd_data),
    .cap_valid     (cap_valid),
    .cap_ovf       (cap_ovf),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_val[i] = '0;
    m_full = '0;
    m_ovf  = '0;
    m_irq  = 1'b0;
  endtask

  // Advance one clock: the model consumes the inputs held across the edge, then pulses drop.
  task automatic tick();
    bit [7:0] nf = m_full;
    bit [7:0] no = m_ovf;
    bit       ni = |(m_full & irq_en);
    for (int i = 0; i < NCH; i++) begin
      bit took = edge_detected[i] && cap_en[i];
      bit read = rd_ack && (int'(rd_ch) == i);
      if (took) begin
        if (m_full[i] && !read) no[i] = 1'b1;
        else if (ovf_clr[i])    no[i] = 1'b0;
        m_val[i] = count;
        nf[i] = 1'b1;
      end else begin
        if (read)       nf[i] = 1'b0;
        if (ovf_clr[i]) no[i] = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    m_full = nf;
    m_ovf  = no;
    m_irq  = ni;
    edge_detected = '0;
    rd_ack  = 1'b0;
    ovf_clr = '0;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".valid"}, {24'h0, cap_valid}, {24'h0, m_full});
    chk({tag, ".ovf"},   {24'h0, cap_ovf},   {24'h0, m_ovf});
    chk({tag, ".irq"},   {31'h0, irq},       {31'h0, m_irq});
    chk({tag, ".rd"},    rd_data,            m_val[rd_ch]);
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < NCH; i++) begin
      rd_ch = 3'(i);
      #1;
      chk({tag, ".sweep"}, rd_data, m_val[i]);
    end
  endtask

  initial begin
    model_reset();
    #12;
    chk("rst.valid", {24'h0, cap_valid}, 32'h0);
    chk("rst.ovf",   {24'h0, cap_ovf},   32'h0);
    chk("rst.irq",   {31'h0, irq},       32'h0);
    chk("rst.rd",    rd_data,            32'h0);
    n_rst = 1'b1;
    @(posedge clk); #1;

    // First capture on channel 0.
    cap_en = 8'hFF; irq_en = 8'h01; count = 32'h10; edge_detected = 8'h01; rd_ch = 0;
    tick();
    chk("s1.valid", {24'h0, cap_valid}, 32'h01);
    chk("s1.rd", rd_data, 32'h10);
    chk("s1.irq_early", {31'h0, irq}, 32'h0);
    tick();
    chk("s1.irq", {31'h0, irq}, 32'h1);
    rd_ack = 1'b1;
    tick();
    chk_model("s1.ack");

    // Disabled channel ignores its edge.
    cap_en = 8'hF7; count = 32'h55; edge_detected = 8'h08; rd_ch = 3;
    tick();
    chk("s2.valid3", {31'h0, cap_valid[3]}, 32'h0);
    chk("s2.rd3", rd_data, 32'h0);
    cap_en = 8'hFF;

    // Overrun on channel 2, then clear.
    rd_ch = 2; count = 32'h20; edge_detected = 8'h04;
    tick();
    count = 32'h30; edge_detected = 8'h04;
    tick();
    chk("s3.rd", rd_data, 32'h30);
    chk("s3.ovf2", {31'h0, cap_ovf[2]}, 32'h1);
    ovf_clr = 8'h04;
    tick();
    chk("s3.ovf2_clr", {31'h0, cap_ovf[2]}, 32'h0);
    chk("s3.valid2", {31'h0, cap_valid[2]}, 32'h1);
    // Overrun and clear in the same cycle: the set wins.
    count = 32'h31; edge_detected = 8'h04; ovf_clr = 8'h04;
    tick();
    chk("s3.setwins", {31'h0, cap_ovf[2]}, 32'h1);

    // Same-cycle capture and ack on channel 1.
    rd_ch = 1; count = 32'h40; edge_detected = 8'h02;
    tick();
    count = 32'h44; edge_detected = 8'h02; rd_ack = 1'b1;
    tick();
    chk("s4.valid1", {31'h0, cap_valid[1]}, 32'h1);
    chk("s4.rd", rd_data, 32'h44);
    chk("s4.ovf1", {31'h0, cap_ovf[1]}, 32'h0);
    chk_model("s4");

    // Wrap-around values captured raw on channel 4.
    rd_ch = 4; count = 32'hFFFF_FFFE; edge_detected = 8'h10;
    tick();
    chk("s5.rd_hi", rd_data, 32'hFFFF_FFFE);
    rd_ack = 1'b1;
    tick();
    chk("s5.empty", {31'h0, cap_valid[4]}, 32'h0);
    rd_ack = 1'b1;   // ack on an empty channel does nothing
    tick();
    count = 32'h0000_0003; edge_detected = 8'h10;
    tick();
    chk("s5.rd_lo", rd_data, 32'h3);
    chk("s5.ovf4", {31'h0, cap_ovf[4]}, 32'h0);
    chk_model("s5");

    // Disabling capture keeps the pending value.
    cap_en = 8'h00;
    tick();
    chk("s6.keep", {31'h0, cap_valid[4]}, 32'h1);
    cap_en = 8'hFF;

    // Fill everything, then async reset between edges.
    irq_en = 8'hFF; count = 32'h77; edge_detected = 8'hFF;
    tick();
    tick();
    chk("s7.full", {24'h0, cap_valid}, 32'hFF);
    chk("s7.irq", {31'h0, irq}, 32'h1);
    #2 n_rst = 1'b0;
    #1;
    model_reset();
    chk("s7.valid0", {24'h0, cap_valid}, 32'h0);
    chk("s7.ovf0", {24'h0, cap_ovf}, 32'h0);
    chk("s7.irq0", {31'h0, irq}, 32'h0);
    chk("s7.rd0", rd_data, 32'h0);
    count = 32'h99; edge_detected = 8'hFF;  // edge while held in reset is dropped
    @(posedge clk); #1;
    edge_detected = '0;
    chk("s7.held", {24'h0, cap_valid}, 32'h0);
    #2 n_rst = 1'b1;
    @(posedge clk); #1;
    irq_en = 8'h01; rd_ch = 0; count = 32'h10; edge_detected = 8'h01;
    tick();
    chk("s8.valid", {24'h0, cap_valid}, 32'h01);
    chk("s8.rd", rd_data, 32'h10);
    tick();
    chk("s8.irq", {31'h0, irq}, 32'h1);
    sweep("s8");

    // Randomized run.
    for (int n = 0; n < 400; n++) begin
      count         = count + 32'($urandom_range(1, 1000));
      if (n % 50 == 7) count = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      edge_detected = 8'($urandom) & 8'($urandom);
      cap_en        = 8'($urandom) | 8'($urandom);
      irq_en        = 8'($urandom);
      rd_ch         = 3'($urandom);
      rd_ack        = 1'($urandom);
      ovf_clr       = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      tick();
      chk_model("rnd");
      if (n % 40 == 0) sweep("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/timer_input_capture.md
# timer_input_capture

Per-channel input-capture stage for the APB timer. It consumes the per-channel edge pulses from the timer's edge-detection stage and latches the free-running timer count into a capture register on each detected edge. It tracks pending (unread) captures and overruns per channel, presents one selected channel to the APB register file for read-and-acknowledge, and raises a level interrupt.

## Interface
- NUM_CH, 8, number of capture channels; must equal the edge detector's WIDTH.
- CNT_WIDTH, 32, width of the timer count and of each capture register.
- CH_IDX_W, $clog2(NUM_CH) (minimum 1), width of the channel select.
- clk  input  1  system clock; all state updates on the rising edge.
- n_rst  input  1  reset; asynchronous, active-low.
- count  input  CNT_WIDTH  free-running timer count, valid every cycle.
- edge_detected  input  NUM_CH  per-channel single-cycle edge pulse from the edge-detection stage.
- cap_en  input  NUM_CH  per-channel capture enable (control register bit).
- irq_en  input  NUM_CH  per-channel interrupt enable.
- rd_ch  input  CH_IDX_W  channel selected for read.
- rd_ack  input  1  one-cycle pulse: the APB read of the capture register for rd_ch has completed.
- ovf_clr  input  NUM_CH  write-one-to-clear for the overrun flags.
- rd_data  output  CNT_WIDTH  capture register of channel rd_ch (combinational mux).
- cap_valid  output  NUM_CH  capture pending (unread) per channel.
- cap_ovf  output  NUM_CH  overrun sticky flag per channel.
- irq  output  1  registered interrupt: OR over channels of (cap_valid & irq_en).

## Operation
- Capture event for channel i: edge_detected[i] & cap_en[i]. Edges on disabled channels are ignored and leave no state.
- On a capture event, cap_reg[i] <= count sampled in the same cycle, and cap_valid[i] <= 1.
- Each channel is a two-state machine:
  - EMPTY: cap_valid = 0.
  - FULL: cap_valid = 1.
  - EMPTY -> FULL on a capture.
  - FULL -> EMPTY on an ack (rd_ack with rd_ch == i) with no capture in the same cycle.
  - FULL -> FULL on a capture without an ack: cap_reg is overwritten with the newest count and cap_ovf[i] <= 1.
- Capture and ack on the same channel in the same cycle: the new value is stored, cap_valid stays 1, and cap_ovf is unchanged. The old value counts as read.
- Ack on an EMPTY channel has no effect.
- rd_ch >= NUM_CH: rd_data = 0 and rd_ack is ignored.
- cap_ovf[i] clears only on ovf_clr[i]. If an overrun and ovf_clr occur in the same cycle, the set wins.
- Clearing cap_en[i] does not discard a pending capture.
- Count wrap-around needs no special handling: the raw count is captured, and software computes differences modulo 2^CNT_WIDTH.

## Timing
- Reset values:
  - cap_reg = 0 for all channels.
  - cap_valid = 0.
  - cap_ovf = 0.
  - irq = 0.
  - rd_data = 0.
- Capture latency: an edge pulse in cycle N makes rd_data and cap_valid show the cycle-N count in cycle N+1.
- irq is registered: it asserts in cycle N+2 after an edge in cycle N, and deasserts one cycle after the last enabled valid clears.
- An ack in cycle N clears cap_valid in cycle N+1.
- rd_data follows rd_ch combinationally with no added latency.
- Reset asserted mid-operation clears all state immediately; no capture completes while n_rst is low.
- Captures on all channels in one cycle are all taken; there is no arbitration.

## Structure
- Shared package timer_pkg holds:
  - default NUM_CH and CNT_WIDTH;
  - the channel state enum (CAP_EMPTY, CAP_FULL);
  - capture_event helper typedefs.
- Sub-module capture_channel (one instance per channel via generate) holds cap_reg, the state machine and the ovf flag. The top level contains the rd_ch decode, the rd_data mux and the irq register.

## Test plan
- Reset, then count=32'h10, edge_detected=8'h01, cap_en=8'hFF -> next cycle: cap_valid=8'h01, rd_data (rd_ch=0) = 32'h10, cap_ovf=0. irq=1 one cycle later if irq_en[0]=1.
- Edge on channel 3 with cap_en[3]=0, count=32'h55 -> cap_valid stays 0 and cap_reg[3] stays 0.
- Overrun on channel 2: captures at count 32'h20, then 32'h30, no ack -> rd_data=32'h30, cap_ovf[2]=1. ovf_clr[2] pulse -> cap_ovf[2]=0 and cap_valid[2] stays 1.
- Same-cycle capture and ack on channel 1: pending 32'h40, then rd_ack with rd_ch=1 plus an edge at count 32'h44 -> cap_valid[1]=1, rd_data=32'h44, cap_ovf[1]=0.
- Wrap: capture at count=32'hFFFF_FFFE, then ack, then capture at 32'h0000_0003 -> values read back exactly, with no overflow flag.
- n_rst pulsed low asynchronously (between clock edges) with all channels FULL and irq=1 -> all outputs are 0 immediately, and the first capture after reset behaves as in the first scenario.
